// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: default widths, function encodings
// and FSM state encodings.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int FUNC_W = 3;
    localparam int CNT_W  = 8;

    localparam logic [FUNC_W-1:0] FN_INC    = 3'b000;
    localparam logic [FUNC_W-1:0] FN_ADD_RC = 3'b001;
    localparam logic [FUNC_W-1:0] FN_ADD    = 3'b010;
    localparam logic [FUNC_W-1:0] FN_ORXOR  = 3'b011;
    localparam logic [FUNC_W-1:0] FN_REDOR  = 3'b100;
    localparam logic [FUNC_W-1:0] FN_CAT    = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: two DATA_W operands and a function select produce a
// 2*DATA_W result {hi, lo}.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int FUNC_W = 3
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [FUNC_W-1:0]   func,
    output logic [2*DATA_W-1:0] y
);

    logic [DATA_W-1:0] rc_sum;
    logic [DATA_W:0]   rc_carry;

    // Ripple-carry adder chain kept as an explicit bit loop.
    always_comb begin
        rc_sum      = '0;
        rc_carry    = '0;
        rc_carry[0] = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            rc_sum[i]     = a[i] ^ b[i] ^ rc_carry[i];
            rc_carry[i+1] = (a[i] & b[i]) | (rc_carry[i] & (a[i] ^ b[i]));
        end
    end

    always_comb begin
        y = '0;
        case (func)
            FN_INC:    y[DATA_W:0] = {1'b0, a} + (DATA_W+1)'(1);
            FN_ADD_RC: y[DATA_W:0] = {rc_carry[DATA_W], rc_sum};
            FN_ADD:    y[DATA_W:0] = {1'b0, a} + {1'b0, b};
            FN_ORXOR:  y           = {a | b, a ^ b};
            FN_REDOR:  y[0]        = |(a | b);
            FN_CAT:    y           = {a, b};
            default:   y           = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU: capture on handshake,
// compute for one cycle, hold the registered result until accepted.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int FUNC_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic [FUNC_W-1:0]   req0_func,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    input  logic [FUNC_W-1:0]   req1_func,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_data,
    output logic                rsp_id,
    output logic [CNT_W-1:0]    op_count
);

    logic [1:0]          state;
    logic                last_grant;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [FUNC_W-1:0]   op_func;
    logic                op_id;
    logic                grant_valid;
    logic                grant_id;
    logic [2*DATA_W-1:0] alu_y;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is also held low while reset is asserted, since state already reads IDLE then.
    assign req0_ready = resetn && (state == ST_IDLE) && grant_valid && !grant_id;
    assign req1_ready = resetn && (state == ST_IDLE) && grant_valid &&  grant_id;

    alu_core #(
        .DATA_W (DATA_W),
        .FUNC_W (FUNC_W)
    ) u_alu_core (
        .a    (op_a),
        .b    (op_b),
        .func (op_func),
        .y    (alu_y)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_func    <= '0;
            op_id      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        op_a       <= grant_id ? req1_a    : req0_a;
                        op_b       <= grant_id ? req1_b    : req0_b;
                        op_func    <= grant_id ? req1_func : req0_func;
                        op_id      <= grant_id;
                        last_grant <= grant_id;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= alu_y;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against an arithmetic
// reference model of the ALU functions, round-robin grant and op counter.
module tb_alu_arbiter;

    logic       clock;
    logic       resetn;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_func, req1_func;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [7:0] rsp_data;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;

    // model state
    bit p0, p1;
    int m_last;
    int m_count;
    logic [7:0] seen_data;

    alu_arbiter #(
        .DATA_W (4),
        .FUNC_W (3),
        .CNT_W  (8)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_func  (req0_func),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_func  (req1_func),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .op_count   (op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_alu(input int a, input int b, input int f);
        int r;
        case (f)
            0:       r = a + 1;
            1, 2:    r = a + b;
            3:       r = (a | b) * 16 + (a ^ b);
            4:       r = ((a | b) != 0) ? 1 : 0;
            5:       r = a * 16 + b;
            default: r = 0;
        endcase
        return 8'(r % 256);
    endfunction

    task automatic new_op0();
        p0 = 1; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_func = 3'($urandom);
    endtask

    task automatic new_op1();
        p1 = 1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_func = 3'($urandom);
    endtask

    // One complete transaction from IDLE to acceptance, with `hold` stall cycles.
    task automatic txn(input int hold);
        int w;
        logic [7:0] exp_d;
        @(negedge clock);
        req0_valid = p0;
        req1_valid = p1;
        #1;
        w = (p0 && p1) ? (m_last == 0 ? 1 : 0) : (p0 ? 0 : 1);
        exp_d = (w == 0) ? ref_alu(req0_a, req0_b, req0_func) : ref_alu(req1_a, req1_b, req1_func);
        check("idle_ready0", req0_ready, w == 0);
        check("idle_ready1", req1_ready, w == 1);
        rsp_ready = 1'($urandom);
        @(posedge clock); #1;
        // winner drops valid and scrambles operands; only the handshake sample may count
        if (w == 0) begin
            p0 = 0; req0_valid = 0; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_func = 3'($urandom);
        end else begin
            p1 = 0; req1_valid = 0; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_func = 3'($urandom);
        end
        check("exec_ready", {req0_ready, req1_ready}, 2'b00);
        check("exec_rsp_valid", rsp_valid, 1'b0);
        rsp_ready = 1'($urandom);
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        seen_data = rsp_data;
        check("hold_rsp_valid", rsp_valid, 1'b1);
        check("hold_rsp_data", rsp_data, exp_d);
        check("hold_rsp_id", rsp_id, w);
        check("hold_ready", {req0_ready, req1_ready}, 2'b00);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_data", rsp_data, exp_d);
            check("stall_ready", {req0_ready, req1_ready}, 2'b00);
            check("stall_count", op_count, m_count);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        m_count = (m_count + 1) % 256;
        m_last = w;
        check("done_rsp_valid", rsp_valid, 1'b0);
        check("done_count", op_count, m_count);
    endtask

    initial begin
        m_last = 1; m_count = 0; p0 = 0; p1 = 0;
        resetn = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'h3; req0_b = 4'h4; req0_func = 3'd1;
        req1_a = 4'h1; req1_b = 4'h2; req1_func = 3'd1;

        // reset held 3 cycles with both requesters valid
        repeat (3) begin
            @(negedge clock);
            check("rst_ready", {req0_ready, req1_ready}, 2'b00);
            check("rst_rsp_valid", rsp_valid, 1'b0);
            check("rst_rsp_data", rsp_data, 8'h00);
            check("rst_rsp_id", rsp_id, 1'b0);
            check("rst_count", op_count, 8'd0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        resetn = 1'b1;

        // reset pulsed during EXEC aborts the op
        @(negedge clock);
        req0_valid = 1'b1; #1;
        check("abort_ready0", req0_ready, 1'b1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        resetn = 1'b0; #1;
        check("abort_rsp_valid", rsp_valid, 1'b0);
        repeat (2) begin
            @(negedge clock);
            check("abort_rsp_valid_low", rsp_valid, 1'b0);
            check("abort_count", op_count, 8'd0);
        end
        @(negedge clock); resetn = 1'b1;
        repeat (2) begin
            @(posedge clock); #1;
            check("post_abort_rsp_valid", rsp_valid, 1'b0);
            check("post_abort_count", op_count, 8'd0);
        end
        m_last = 1; m_count = 0;

        // contention from reset: req0 first, then req1, then alternating
        p0 = 1; req0_a = 4'hA; req0_b = 4'h5; req0_func = 3'b011;
        p1 = 1; req1_a = 4'hF; req1_b = 4'h0; req1_func = 3'b000;
        txn(0);
        check("cont_first_data", seen_data, 8'hFF);
        check("cont_first_id", rsp_id, 1'b0);
        new_op0();
        txn(0);
        check("cont_second_data", seen_data, 8'h10);
        check("cont_second_id", rsp_id, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (!p0) new_op0();
            if (!p1) new_op1();
            txn($urandom_range(0, 2));
            check("alt_id", rsp_id, (i % 2 == 0) ? 1'b0 : 1'b1);
        end
        p1 = 0; req1_valid = 1'b0;

        // single requester ripple-carry add
        p0 = 1; req0_a = 4'h7; req0_b = 4'h9; req0_func = 3'b001;
        txn(0);
        check("rc_add_data", seen_data, 8'h10);

        // backpressure for 5 cycles
        p0 = 1; req0_a = 4'hC; req0_b = 4'h3; req0_func = 3'b101;
        txn(5);
        check("bp_data", seen_data, 8'hC3);

        // unused function codes
        p0 = 1; req0_a = 4'hF; req0_b = 4'hF; req0_func = 3'b110;
        txn(1);
        check("fn110_data", seen_data, 8'h00);
        p1 = 1; req1_a = 4'h9; req1_b = 4'h6; req1_func = 3'b111;
        txn(0);
        check("fn111_data", seen_data, 8'h00);

        // random traffic, enough to wrap the op counter
        for (int n = 0; n < 280; n++) begin
            if (!p0 && ($urandom_range(0, 2) != 0)) new_op0();
            if (!p1 && ($urandom_range(0, 2) != 0)) new_op1();
            if (!p0 && !p1) new_op0();
            txn(($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
